// File: rtl/hs_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : hs_rx_fifo_if
// Description : Receiver-ack/data input side and valid/ready output stream
//               of hs_rx_fifo, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface hs_rx_fifo_if #(
  parameter int WIDTH = 4
);
  logic             hs_ack;
  logic [WIDTH-1:0] hs_data;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  // Environment side: drives the receiver signals and the consumer ready
  modport master (
    output hs_ack, hs_data, m_ready,
    input  m_valid, m_data
  );

  // FIFO side
  modport slave (
    input  hs_ack, hs_data, m_ready,
    output m_valid, m_data
  );
endinterface
`default_nettype wire

// File: rtl/hs_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hs_rx_fifo
// Description : Captures one word per rising edge of the handshake ack into a
//               DEPTH-entry FIFO, presented on a valid/ready stream. Never
//               back-pressures; drops are flagged by sticky overflow.
//               Define HS_RXBUF_DROPCNT_EN to add the saturating drop_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_rx_fifo #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  wire logic          rclk,
  input  wire logic          reset_n,
  hs_rx_fifo_if.slave        bus,
  output logic [LW-1:0]      level,
  output logic               full,
  output logic               empty,
  output logic               overflow,
`ifdef HS_RXBUF_DROPCNT_EN
  output logic [7:0]         drop_cnt,
`endif
  input  wire logic          clr_ovf
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_pw = c_aw + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_pw-1:0]  r_wr_ptr;
  logic [c_pw-1:0]  r_rd_ptr;
  logic [c_pw-1:0]  w_wr_nxt;
  logic [c_pw-1:0]  w_rd_nxt;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_level_nxt;
  logic             r_full;
  logic             r_empty;
  logic             r_ovf;
  logic             r_ack_q;
  logic             w_strobe;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  // r_ack_q resets high so an ack already asserted at release is ignored
  assign w_strobe    = bus.hs_ack & ~r_ack_q;
  assign w_pop       = ~r_empty & bus.m_ready;
  assign w_push      = w_strobe & (~r_full | w_pop);
  assign w_drop      = w_strobe & r_full & ~w_pop;

  assign w_wr_nxt    = r_wr_ptr + c_pw'(w_push);
  assign w_rd_nxt    = r_rd_ptr + c_pw'(w_pop);
  assign w_level_nxt = LW'(c_pw'(w_wr_nxt - w_rd_nxt));

  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_q  <= 1'b1;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      r_ack_q  <= bus.hs_ack;
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_level_nxt;
      r_full   <= (w_level_nxt == LW'(DEPTH));
      r_empty  <= (w_level_nxt == '0);
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // A full FIFO only accepts a write when the head slot is popped that cycle,
  // so the slot under rd_ptr never changes while the head is stalled.
  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= bus.hs_data;
    end
  end

`ifdef HS_RXBUF_DROPCNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      if (clr_ovf) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (clr_ovf) begin
      r_drop_cnt <= 8'd0;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign bus.m_valid = ~r_empty;
  assign bus.m_data  = r_mem[r_rd_ptr[c_aw-1:0]];
  assign level       = r_level;
  assign full        = r_full;
  assign empty       = r_empty;
  assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_hs_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_rx_fifo
// Description : Directed and randomized bench for hs_rx_fifo against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_rx_fifo;

  localparam int c_width = 4;
  localparam int c_depth = 4;

  logic       rclk = 1'b0;
  logic       reset_n;
  logic       clr_ovf;
  logic [2:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
`ifdef HS_RXBUF_DROPCNT_EN
  logic [7:0] drop_cnt;
`endif

  hs_rx_fifo_if #(.WIDTH(c_width)) bus ();

  hs_rx_fifo #(.WIDTH(c_width), .DEPTH(c_depth)) u_dut (
    .rclk     (rclk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
`ifdef HS_RXBUF_DROPCNT_EN
    .drop_cnt (drop_cnt),
`endif
    .clr_ovf  (clr_ovf)
  );

  always #5 rclk = ~rclk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: stored words, last seen ack, sticky flag, drop count
  logic [c_width-1:0] mq[$];
  bit                 m_ackq;
  bit                 m_ovf;
  int                 m_drop;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit ack, input logic [c_width-1:0] d, input bit rdy, input bit clr);
    bit strobe;
    bit dropped;
    strobe  = ack && !m_ackq;
    m_ackq  = ack;
    dropped = 1'b0;
    if (mq.size() != 0 && rdy) void'(mq.pop_front());
    if (strobe) begin
      if (mq.size() < c_depth) mq.push_back(d);
      else dropped = 1'b1;
    end
    if (dropped) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
  endtask

  task automatic compare_all();
    chk("m_valid", bus.m_valid, mq.size() != 0);
    if (mq.size() != 0) chk("m_data", bus.m_data, mq[0]);
    chk("level", level, mq.size());
    chk("full", full, mq.size() == c_depth);
    chk("empty", empty, mq.size() == 0);
    chk("overflow", overflow, m_ovf);
`ifdef HS_RXBUF_DROPCNT_EN
    chk("drop_cnt", drop_cnt, m_drop);
`endif
  endtask

  // Called at a falling edge; applies inputs across one rising edge
  task automatic step(input bit ack, input logic [c_width-1:0] d, input bit rdy, input bit clr);
    bus.hs_ack  = ack;
    bus.hs_data = d;
    bus.m_ready = rdy;
    clr_ovf     = clr;
    @(posedge rclk);
    model_edge(ack, d, rdy, clr);
    @(negedge rclk);
    compare_all();
  endtask

  // Inputs other than reset_n keep their current values throughout
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    mq.delete();
    m_ackq = 1'b1;
    m_ovf  = 1'b0;
    m_drop = 0;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_overflow", overflow, 0);
`ifdef HS_RXBUF_DROPCNT_EN
    chk("rst_drop_cnt", drop_cnt, 0);
`endif
    repeat (2) @(negedge rclk);
    reset_n = 1'b1;
  endtask

  task automatic edge_word(input logic [c_width-1:0] d, input bit rdy);
    step(1'b1, d, rdy, 1'b0);
    step(1'b0, d, rdy, 1'b0);
  endtask

  initial begin
    bit                 a;
    logic [c_width-1:0] dd;
    reset_n     = 1'b1;
    bus.hs_ack  = 1'b0;
    bus.hs_data = '0;
    bus.m_ready = 1'b0;
    clr_ovf     = 1'b0;
    @(negedge rclk);
    do_reset();

    // Single capture shows up the cycle after the ack edge
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'hA, 1'b0, 1'b0);
    chk("t1_valid", bus.m_valid, 1);
    chk("t1_data", bus.m_data, 4'hA);
    chk("t1_level", level, 1);
    chk("t1_empty", empty, 0);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // Long ack pulse yields one capture
    step(1'b1, 4'h3, 1'b1, 1'b0);
    repeat (4) step(1'b1, 4'h3, 1'b0, 1'b0);
    chk("t2_level", level, 1);
    step(1'b0, 4'h3, 1'b1, 1'b0);
    chk("t2_empty", empty, 1);

    // Overfill: fifth word dropped
    for (int i = 1; i <= 5; i++) edge_word(4'(i), 1'b0);
    chk("t3_full", full, 1);
    chk("t3_level", level, 4);
    chk("t3_overflow", overflow, 1);
`ifdef HS_RXBUF_DROPCNT_EN
    chk("t3_drop_cnt", drop_cnt, 1);
`endif
    repeat (4) step(1'b0, 4'h0, 1'b1, 1'b0);
    chk("t3_empty", empty, 1);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // Push into a full FIFO while popping
    for (int i = 1; i <= 4; i++) edge_word(4'(i + 10), 1'b0);
    step(1'b1, 4'h6, 1'b1, 1'b0);
    chk("t4_level", level, 4);
    chk("t4_overflow", overflow, 0);
    step(1'b0, 4'h6, 1'b0, 1'b0);
    repeat (4) step(1'b0, 4'h0, 1'b1, 1'b0);

    // Pointer wrap with interleaved pops
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'(i + 2), 1'b0, 1'b0);
      step(1'b0, 4'h0, (i % 2) == 1, 1'b0);
    end
    repeat (4) step(1'b0, 4'h0, 1'b1, 1'b0);

    // Randomized traffic with occasional clears
    a = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0) a = ~a;
      dd = 4'($urandom);
      step(a, dd, $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
    end

    // Reset mid-operation with ack held high across release
    step(1'b0, 4'h0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 4'h0, 1'b1, 1'b0);
    edge_word(4'h1, 1'b0);
    edge_word(4'h2, 1'b0);
    step(1'b1, 4'h3, 1'b0, 1'b0);
    chk("t6_level_pre", level, 3);
    do_reset();
    repeat (3) step(1'b1, 4'h7, 1'b0, 1'b0);
    chk("t6_empty", empty, 1);
    step(1'b0, 4'h7, 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b0, 1'b0);
    chk("t6_data", bus.m_data, 4'h9);
    chk("t6_valid", bus.m_valid, 1);
    step(1'b0, 4'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
